// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - multi-cycle HI/LO multiply/divide sequencer
// Results are computed at accept, held in a shadow pair, and committed after the latency window.
module md_sequencer #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        int_req,
  input  logic        rollback,
  input  logic        hilo_sel,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam int CW = 8;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   res_hi_q, res_lo_q;
  logic          res_wr_q;

  logic          accept;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   q_s, r_s, q_u, r_u;

  assign accept = (state_q == IDLE) && start && !int_req;

  // Sign-extending to 64 bits makes a plain multiply yield the signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

  always_comb begin
    q_s = '0;
    r_s = '0;
    q_u = '0;
    r_u = '0;
    if (b != 32'd0) begin
      q_u = a / b;
      r_u = a % b;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q_s = 32'h8000_0000;
        r_s = 32'd0;
      end else begin
        q_s = $signed(a) / $signed(b);
        r_s = $signed(a) % $signed(b);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      res_wr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (md_op)
              3'd0, 3'd1: begin
                {res_hi_q, res_lo_q} <= (md_op == 3'd0) ? prod_s : prod_u;
                res_wr_q <= 1'b1;
                cnt_q    <= CW'(MULT_LAT);
                state_q  <= MUL;
              end
              3'd2, 3'd3: begin
                res_hi_q <= (md_op == 3'd2) ? r_s : r_u;
                res_lo_q <= (md_op == 3'd2) ? q_s : q_u;
                // Divide by zero still spends the full latency but commits nothing.
                res_wr_q <= (b != 32'd0);
                cnt_q    <= CW'(DIV_LAT);
                state_q  <= DIV;
              end
              3'd4: hi_q <= a;
              3'd5: lo_q <= a;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          if (rollback) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            res_wr_q <= 1'b0;
          end else if (cnt_q == CW'(1)) begin
            if (res_wr_q) begin
              hi_q <= res_hi_q;
              lo_q <= res_lo_q;
            end
            state_q  <= IDLE;
            cnt_q    <= '0;
            res_wr_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = hilo_sel ? hi_q : lo_q;

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 Parameter MULT_LAT, default 5: cycles busy is held for mult/multu.
REQ-002 Parameter DIV_LAT, default 10: cycles busy is held for div/divu.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-005 start  input  1  EX-stage request, valid for one cycle; qualified by md_op.
REQ-006 md_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved (no-op).
REQ-007 a  input  32  forwarded rs operand.
REQ-008 b  input  32  forwarded rt operand.
REQ-009 int_req  input  1  exception/interrupt taken this cycle; squashes the EX-stage request.
REQ-010 rollback  input  1  abort of an in-flight operation (eret/flush).
REQ-011 hilo_sel  input  1  read select: 0 LO, 1 HI (mflo/mfhi).
REQ-012 busy  output  1  registered; high while a mult/div is in flight.
REQ-013 rd_data  output  32  combinational HI or LO per hilo_sel.
REQ-014 hi  output  32  current HI register.
REQ-015 lo  output  32  current LO register.

Function
REQ-016 States SHALL be IDLE, MUL, DIV; busy = (state != IDLE).
REQ-017 A start is accepted only when state == IDLE, start == 1 and int_req == 0.
REQ-018 start while busy SHALL be ignored (no state, counter or HI/LO change); the hazard unit stalls on start|busy.
REQ-019 Accepted mult/multu: latch the 64-bit product of a, b (signed / unsigned), load counter with MULT_LAT, go to MUL.
REQ-020 Accepted div/divu: latch quotient and remainder (signed / unsigned), load counter with DIV_LAT, go to DIV.
REQ-021 In MUL/DIV the counter decrements each cycle; on the cycle it reaches 1, HI/LO are written at that edge and state returns to IDLE, so busy is high exactly LAT cycles, starting the cycle after start.
REQ-022 HI/LO SHALL hold their pre-operation values until the completing edge; rd_data during busy returns those old values.
REQ-023 mult: HI = product[63:32], LO = product[31:0].
REQ-024 div: LO = quotient, HI = remainder; signed quotient truncates toward zero, remainder takes the sign of a.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0x00000000.
REQ-026 Divide by zero: full DIV_LAT busy period, then HI/LO unchanged.
REQ-027 Accepted mthi/mtlo: HI or LO = a at the same edge, no busy cycle, state stays IDLE.
REQ-028 Reserved md_op with start SHALL have no effect.
REQ-029 int_req with start: request dropped, nothing written, busy stays 0.
REQ-030 rollback while busy: next edge state = IDLE, busy = 0, HI/LO keep pre-operation values, latched result discarded.
REQ-031 rollback on the completing cycle SHALL take priority: no HI/LO write.
REQ-032 rollback or int_req while IDLE with no start: no effect.
REQ-033 Completion and a new start in the same cycle: start is ignored (state not yet IDLE); it is accepted the following cycle.

Reset
REQ-034 reset low, at any time including mid-operation: state = IDLE, counter = 0, busy = 0, HI = LO = 0 asynchronously; the latched result is discarded.
REQ-035 After reset deassertion, the first start is accepted on the first rising edge.

Verification
REQ-036 mult a=0xFFFFFFFE, b=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-037 div a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu a=7, b=0 -> 10 busy cycles, HI/LO unchanged.
REQ-038 mtlo a=0x1234 while IDLE -> LO=0x1234 next edge, busy never high; start+int_req with mthi -> HI unchanged.
REQ-039 div started, rollback at busy cycle 4 -> busy low next cycle; HI/LO equal pre-div values; new mult then completes normally.
REQ-040 reset low at busy cycle 3 of mult -> busy, HI, LO = 0 immediately, without a clock edge.
REQ-041 start asserted on every busy cycle -> only the first is accepted; mfhi/mflo (rd_data) return old values until the completing edge.
